// File: rtl/uart_rx.sv
// 8N1 UART receiver with synchronised input, mid-bit sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          par_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          pe_q, pe_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
            if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              pe_d = 1'b1;
`endif
            end else begin
              // A commit alongside a handshake replaces the byte without overrun.
              data_d  = shift_q;
              valid_d = 1'b1;
              ov_d    = valid_q && !ready;
            end
          end else begin
            fe_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_d    = par_bad;
`endif
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16; accepted bytes are checked by a monitor.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edges from driving the start bit low to the edge where valid is first high.
  localparam int LAT = SYNC + C / 2 + 9 * C + PBITS * C + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (busy)       busy_cnt++;
      if (valid && !valid_prev) rise_cyc = cyc;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", data);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_data", {24'd0, data}, {24'd0, e});
        end
      end
    end
    valid_prev = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                           input bit rdy_pulse, input int abort_bit);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (C) tick();
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == abort_bit) begin
        repeat (C / 2) tick();
        return;
      end
      repeat (C) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    repeat (C) tick();
`else
    if (!par_ok) rx = 1'b1;
`endif
    rx = stop_ok;
    for (int i = 0; i < C; i++) begin
      tick();
      if (rdy_pulse && i == 9)  ready = 1'b1;
      if (rdy_pulse && i == 10) ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, f0, o0, p0;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) tick();
    check("rst_data",  {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_fe",    {31'd0, frame_err}, 32'h0);
    check("rst_ov",    {31'd0, overrun}, 32'h0);
    check("rst_pe",    {31'd0, parity_err}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Basic byte, ready held low
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0, -1);
    check("latency", rise_cyc - start_cyc, LAT);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_valid", {31'd0, valid}, 32'h1);
    repeat (20) tick();
    check("a5_hold_valid", {31'd0, valid}, 32'h1);
    check("a5_hold_data", {24'd0, data}, 32'hA5);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("a5_cleared", {31'd0, valid}, 32'h0);

    // Short low glitch
    b0 = busy_cnt; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_busy_cycles", busy_cnt - b0, C / 2);
    check("glitch_valid", {31'd0, valid}, 32'h0);
    check("glitch_busy_end", {31'd0, busy}, 32'h0);
    check("glitch_flags", (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0), 0);

    // Framing error followed by long break
    f0 = fe_cnt;
    send_byte(8'h3C, 1'b0, 1'b1, 1'b0, -1);
    repeat (40 * C) tick();
    check("fe_pulse_cycles", fe_cnt - f0, 1);
    check("fe_valid", {31'd0, valid}, 32'h0);
    check("fe_break_busy", {31'd0, busy}, 32'h1);
    rx = 1'b1;
    repeat (2 * C) tick();
    check("fe_idle_busy", {31'd0, busy}, 32'h0);
    ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) tick();
    ready = 1'b0;
    check("after_fe_drained", exp_q.size(), 0);

    // Overrun: 8'h11 is lost, 8'h22 overwrites it
    o0 = ov_cnt;
    exp_q.push_back(8'h22);
    send_byte(8'h11, 1'b1, 1'b1, 1'b0, -1);
    send_byte(8'h22, 1'b1, 1'b1, 1'b0, -1);
    check("ov_pulse_cycles", ov_cnt - o0, 1);
    check("ov_data", {24'd0, data}, 32'h22);
    check("ov_valid", {31'd0, valid}, 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Handshake coincides with the second commit: no overrun
    o0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_byte(8'h11, 1'b1, 1'b1, 1'b0, -1);
    send_byte(8'h22, 1'b1, 1'b1, 1'b1, -1);
    check("noov_pulses", ov_cnt - o0, 0);
    check("noov_valid", {31'd0, valid}, 32'h1);
    check("noov_data", {24'd0, data}, 32'h22);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("noov_drained", exp_q.size(), 0);

    // Reset during bit 4
    send_byte(8'hF0, 1'b1, 1'b1, 1'b0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_data",  {24'd0, data}, 32'h0);
    check("mid_rst_valid", {31'd0, valid}, 32'h0);
    check("mid_rst_busy",  {31'd0, busy}, 32'h0);
    check("mid_rst_flags", {29'd0, frame_err, overrun, parity_err}, 32'h0);
    repeat (2) tick();
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (2 * C) tick();
    check("post_rst_busy", {31'd0, busy}, 32'h0);
    check("post_rst_valid", {31'd0, valid}, 32'h0);
    ready = 1'b1;
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) tick();
    ready = 1'b0;
    check("post_rst_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    ready = 1'b1;
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) tick();
    ready = 1'b0;
    check("par_ok_drained", exp_q.size(), 0);
    p0 = pe_cnt;
    send_byte(8'h07, 1'b1, 1'b0, 1'b0, -1);
    repeat (4) tick();
    check("par_err_pulses", pe_cnt - p0, 1);
    check("par_err_valid", {31'd0, valid}, 32'h0);
`else
    check("parity_err_never", pe_cnt, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
